rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
Parametrised reservation station for the out-of-order core, successor to the single-ALU RS. It holds DEPTH decoded ALU ops and snoops NCDB result buses for operand wakeup. It dispatches one ready op per cycle over a valid/ready handshake to an external ALU. It sits between the decoder/ROB issue stage and the ALU, and is cleared by the ROB flush.

Parameters:
DEPTH, 8, number of entries, power of two, 2..32
NCDB, 2, number of CDB channels snooped (RS ALU, LSB, ...)
XLEN, 32, operand/PC/immediate width
TAG_W, 4, ROB tag width
OP_W, 6, opcode width (same encoding as decoder OP_* constants)

Ports:
clk  in  1  clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; low = hold all state
flush_in  in  1  ROB mispredict flush
issue_valid  in  1  decoder presents op
issue_ready  out  1  free entry exists
issue_op  in  OP_W  opcode
issue_tag  in  TAG_W  ROB destination tag
issue_pc  in  XLEN  instruction PC
issue_imm  in  XLEN  immediate
issue_rdy1 / issue_rdy2  in  1  source operand already valid
issue_q1 / issue_q2  in  TAG_W  producer tag when not ready
issue_v1 / issue_v2  in  XLEN  operand value when ready
cdb_valid  in  NCDB  per-channel broadcast valid
cdb_tag  in  NCDB*TAG_W  packed tags, channel 0 in LSBs
cdb_val  in  NCDB*XLEN  packed values
disp_valid  out  1  selected op ready for ALU
disp_ready  in  1  ALU accepts
disp_op / disp_tag / disp_pc / disp_imm / disp_v1 / disp_v2  out  OP_W/TAG_W/XLEN x4  dispatched op fields
occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (rst_in=0, async): all entries invalid, occupancy=0, issue_ready=1, disp_valid=0, disp_* fields 0.
- Reset asserted mid-operation: all entries are discarded immediately; no dispatch is completed.
- rdy_in=0: no state changes; issue_ready=0 and disp_valid=0 (combinational masking).
- Issue: accepted on a posedge with rdy_in & issue_valid & issue_ready & !flush_in. Fills the lowest-index free entry.
- Issue-time bypass: if issue_rdyN=0 and any cdb_valid[k] has cdb_tag[k]==issue_qN in the same cycle, the entry is written as ready with cdb_val[k].
- issue_ready = (occupancy < DEPTH), derived from registered state only. A slot freed by dispatch becomes usable the next cycle.
- Wakeup: every cycle, each valid, non-ready source compares against all NCDB channels. On a match it captures the value and sets ready at the edge. On a multi-channel tag match, the lowest channel index wins.
- Eligibility: entry valid & both sources ready (registered state). Minimum issue-to-disp_valid latency is 1 cycle. Wakeup-to-disp_valid latency is 1 cycle.
- Dispatch: disp_* driven combinationally from the selected eligible entry. disp_valid = any eligible & rdy_in & !flush_in. The entry is freed at the edge where disp_valid & disp_ready.
- Selection changes only when the current choice is consumed or a higher-priority entry becomes eligible. The ALU must sample on handshake only.
- Simultaneous issue + dispatch: occupancy unchanged. Issue never targets the entry being freed that cycle.
- Flush: at the edge with flush_in & rdy_in, all entries are invalidated and occupancy=0. Issue and dispatch are ignored in that cycle, and disp_valid=0 during it.
- Operand semantics per op are fixed at issue by the decoder; this block does no opcode-specific rewriting:
  - AUIPC/JAL/LUI/I-type: ALU uses disp_pc/disp_imm.
  - Source 2 arrives with issue_rdy2=1 when unused.

Optional Feature:
RS_AGE_SELECT_EN. When defined:
- Each entry has a $clog2(DEPTH)-bit age rank.
- Selection picks the oldest eligible entry.
- Ranks update on issue and dispatch; flush clears them.

When not defined: selection picks the lowest-index eligible entry and no age state exists.

Decomposition:
- rs_pkg holds:
  - OP_* opcode constants and OP_W.
  - Default XLEN/TAG_W.
  - A packed entry typedef {valid, op, tag, pc, imm, rdy1, q1, v1, rdy2, q2, v2}.
  - A helper function for CDB match/priority.
- Sub-module rs_select (DEPTH param): takes the eligible vector (plus age ranks under RS_AGE_SELECT_EN) and returns the one-hot grant and index. The same instance type is reused for free-slot finding.

Test Plan:
1. Reset then issue ADD tag 3, v1=5, v2=7, both ready -> next cycle disp_valid=1, disp_tag=3, v1=5, v2=7. With disp_ready=1, occupancy returns to 0.
2. Issue tag 4 with q1=2 not ready; CDB channel 1 broadcasts tag 2, val 0x1234 two cycles later -> disp_valid rises the cycle after the broadcast with disp_v1=0x1234.
3. Issue-time bypass: issue q2=6 while cdb_valid[0] has tag 6, val 9 in the same cycle -> disp_valid next cycle with v2=9.
4. Fill DEPTH=8 ready entries with disp_ready=0 -> issue_ready=0 and occupancy=8. Raise disp_ready for 1 cycle -> exactly one entry freed, and issue_ready=1 the following cycle.
5. Flush with 5 entries (3 waiting) plus a simultaneous issue -> next cycle occupancy=0, disp_valid=0, and the issued op is not stored.
6. rdy_in=0 for 3 cycles during a CDB broadcast and issue -> no state change and disp_valid=0. With RS_AGE_SELECT_EN, two entries eligible in the same cycle at indices 5 (older) and 1 -> index 5 dispatches first.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared opcode constants, entry layout and CDB priority helper for the
// reservation station. Optional age-ordered selection: RS_AGE_SELECT_EN.
package rs_pkg;

  localparam int OP_W  = 6;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd10;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd11;
  localparam logic [OP_W-1:0] OP_AND   = 6'd12;
  localparam logic [OP_W-1:0] OP_OR    = 6'd13;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd14;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd20;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             rdy1;
    logic [TAG_W-1:0] q1;
    logic [XLEN-1:0]  v1;
    logic             rdy2;
    logic [TAG_W-1:0] q2;
    logic [XLEN-1:0]  v2;
  } rs_entry_t;

  // Lowest matching channel wins; -1 when no channel matched.
  function automatic int cdb_pick(input logic [31:0] hit);
    int sel;
    sel = -1;
    for (int k = 31; k >= 0; k--)
      if (hit[k]) sel = k;
    return sel;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Priority picker used for both dispatch selection and free-slot finding.
// With RS_AGE_SELECT_EN the smallest age rank wins, ties go to the lowest index.
module rs_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       i_req,
`ifdef RS_AGE_SELECT_EN
  input  logic [DEPTH*IDX_W-1:0] i_age,
`endif
  output logic [DEPTH-1:0]       o_grant,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_any
);

`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0] w_best;
`endif

  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
`ifdef RS_AGE_SELECT_EN
    w_best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_req[i] && (!o_any || (i_age[i*IDX_W +: IDX_W] < w_best))) begin
        o_any  = 1'b1;
        o_idx  = IDX_W'(i);
        w_best = i_age[i*IDX_W +: IDX_W];
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (i_req[i] && !o_any) begin
        o_any = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
`endif
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station snooping NCDB result buses, dispatching one ready op per
// cycle to the ALU. Define RS_AGE_SELECT_EN for oldest-first dispatch.
module rs_multi_cdb #(
  parameter int DEPTH = 8,
  parameter int NCDB  = 2,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [OP_W-1:0]         issue_op,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic [XLEN-1:0]         issue_pc,
  input  logic [XLEN-1:0]         issue_imm,
  input  logic                    issue_rdy1,
  input  logic                    issue_rdy2,
  input  logic [TAG_W-1:0]        issue_q1,
  input  logic [TAG_W-1:0]        issue_q2,
  input  logic [XLEN-1:0]         issue_v1,
  input  logic [XLEN-1:0]         issue_v2,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*TAG_W-1:0]   cdb_tag,
  input  logic [NCDB*XLEN-1:0]    cdb_val,
  output logic                    disp_valid,
  input  logic                    disp_ready,
  output logic [OP_W-1:0]         disp_op,
  output logic [TAG_W-1:0]        disp_tag,
  output logic [XLEN-1:0]         disp_pc,
  output logic [XLEN-1:0]         disp_imm,
  output logic [XLEN-1:0]         disp_v1,
  output logic [XLEN-1:0]         disp_v2,
  output logic [$clog2(DEPTH):0]  occupancy
);
  import rs_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
  logic [IDX_W:0]   r_occ;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [TAG_W-1:0] r_q1  [DEPTH];
  logic [TAG_W-1:0] r_q2  [DEPTH];
  logic [XLEN-1:0]  r_pc  [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [XLEN-1:0]  r_v1  [DEPTH];
  logic [XLEN-1:0]  r_v2  [DEPTH];

  logic [DEPTH-1:0] w_elig, w_disp_grant, w_free_grant;
  logic [DEPTH-1:0] w_wake1, w_wake2, w_rdy1_nxt, w_rdy2_nxt;
  logic [XLEN-1:0]  w_wv1 [DEPTH];
  logic [XLEN-1:0]  w_wv2 [DEPTH];
  logic [XLEN:0]    w_byp1, w_byp2;
  logic [IDX_W-1:0] w_disp_idx, w_free_idx;
  logic             w_any_elig, w_any_free, w_fire, w_issue;

  // {hit, value} of the lowest-index CDB channel broadcasting tag q.
  function automatic logic [XLEN:0] cdb_snoop(input logic [TAG_W-1:0] q);
    logic [31:0] hit;
    int          ch;
    hit = '0;
    for (int k = 0; k < NCDB; k++)
      hit[k] = cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == q);
    ch = cdb_pick(hit);
    if (ch < 0) return '0;
    return {1'b1, cdb_val[ch*XLEN +: XLEN]};
  endfunction

  assign w_elig      = r_valid & r_rdy1 & r_rdy2;
  assign issue_ready = rdy_in && (r_occ < FULL);
  assign disp_valid  = w_any_elig && rdy_in && !flush_in;
  assign w_fire      = disp_valid && disp_ready;
  assign w_issue     = issue_valid && issue_ready && w_any_free && !flush_in;
  assign occupancy   = r_occ;

`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0]       r_age [DEPTH];
  logic [DEPTH*IDX_W-1:0] w_age_flat;
  logic [IDX_W-1:0]       w_new_rank;

  always_comb begin
    w_age_flat = '0;
    for (int i = 0; i < DEPTH; i++) w_age_flat[i*IDX_W +: IDX_W] = r_age[i];
  end
  // A new op ranks behind every entry that survives this edge.
  assign w_new_rank = IDX_W'(r_occ - {{IDX_W{1'b0}}, w_fire});
`endif

  rs_select #(.DEPTH(DEPTH)) u_disp_sel (
    .i_req   (w_elig),
`ifdef RS_AGE_SELECT_EN
    .i_age   (w_age_flat),
`endif
    .o_grant (w_disp_grant),
    .o_idx   (w_disp_idx),
    .o_any   (w_any_elig)
  );

  rs_select #(.DEPTH(DEPTH)) u_free_sel (
    .i_req   (~r_valid),
`ifdef RS_AGE_SELECT_EN
    .i_age   ('0),
`endif
    .o_grant (w_free_grant),
    .o_idx   (w_free_idx),
    .o_any   (w_any_free)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w_wake1[i], w_wv1[i]} = cdb_snoop(r_q1[i]);
      {w_wake2[i], w_wv2[i]} = cdb_snoop(r_q2[i]);
    end
    w_byp1     = cdb_snoop(issue_q1);
    w_byp2     = cdb_snoop(issue_q2);
    w_rdy1_nxt = r_rdy1 | (r_valid & w_wake1);
    w_rdy2_nxt = r_rdy2 | (r_valid & w_wake2);
    if (w_issue) begin
      w_rdy1_nxt[w_free_idx] = issue_rdy1 | w_byp1[XLEN];
      w_rdy2_nxt[w_free_idx] = issue_rdy2 | w_byp2[XLEN];
    end
  end

  always_comb begin
    disp_op  = '0;
    disp_tag = '0;
    disp_pc  = '0;
    disp_imm = '0;
    disp_v1  = '0;
    disp_v2  = '0;
    if (w_any_elig) begin
      disp_op  = r_op[w_disp_idx];
      disp_tag = r_tag[w_disp_idx];
      disp_pc  = r_pc[w_disp_idx];
      disp_imm = r_imm[w_disp_idx];
      disp_v1  = r_v1[w_disp_idx];
      disp_v2  = r_v2[w_disp_idx];
    end
  end

  // Entry bookkeeping: valid/ready bits, occupancy and age ranks.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      r_occ   <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        r_valid <= '0;
        r_occ   <= '0;
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
`endif
      end else begin
        r_valid <= (r_valid & ~(w_fire ? w_disp_grant : '0)) | (w_issue ? w_free_grant : '0);
        r_rdy1  <= w_rdy1_nxt;
        r_rdy2  <= w_rdy2_nxt;
        r_occ   <= r_occ + {{IDX_W{1'b0}}, w_issue} - {{IDX_W{1'b0}}, w_fire};
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < DEPTH; i++)
          if (w_fire && r_valid[i] && (r_age[i] > r_age[w_disp_idx]))
            r_age[i] <= r_age[i] - IDX_W'(1);
        if (w_issue) r_age[w_free_idx] <= w_new_rank;
`endif
      end
    end
  end

  // Entry payload: written on issue, operand values captured on wakeup.
  always_ff @(posedge clk) begin
    if (rdy_in && !flush_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_rdy1[i] && w_wake1[i]) r_v1[i] <= w_wv1[i];
        if (r_valid[i] && !r_rdy2[i] && w_wake2[i]) r_v2[i] <= w_wv2[i];
      end
      if (w_issue) begin
        r_op[w_free_idx]  <= issue_op;
        r_tag[w_free_idx] <= issue_tag;
        r_pc[w_free_idx]  <= issue_pc;
        r_imm[w_free_idx] <= issue_imm;
        r_q1[w_free_idx]  <= issue_q1;
        r_q2[w_free_idx]  <= issue_q2;
        r_v1[w_free_idx]  <= issue_rdy1 ? issue_v1 : w_byp1[XLEN-1:0];
        r_v2[w_free_idx]  <= issue_rdy2 ? issue_v2 : w_byp2[XLEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Self-checking bench for rs_multi_cdb: directed scenarios plus a randomized
// run compared every cycle against a slot-array reference model.
`timescale 1ns/1ps
module tb_rs_multi_cdb;
  localparam int DEPTH = 8;
  localparam int NCDB  = 2;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_in, rdy_in, flush_in;
  logic                   issue_valid, issue_ready;
  logic [OP_W-1:0]        issue_op;
  logic [TAG_W-1:0]       issue_tag, issue_q1, issue_q2;
  logic [XLEN-1:0]        issue_pc, issue_imm, issue_v1, issue_v2;
  logic                   issue_rdy1, issue_rdy2;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_val;
  logic                   disp_valid, disp_ready;
  logic [OP_W-1:0]        disp_op;
  logic [TAG_W-1:0]       disp_tag;
  logic [XLEN-1:0]        disp_pc, disp_imm, disp_v1, disp_v2;
  logic [$clog2(DEPTH):0] occupancy;

  rs_multi_cdb #(.DEPTH(DEPTH), .NCDB(NCDB), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_tag(issue_tag), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2), .issue_q1(issue_q1), .issue_q2(issue_q2),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_tag(disp_tag),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .occupancy(occupancy)
  );

  // Reference model: one record per slot, age kept as an issue sequence number.
  bit               m_valid [DEPTH];
  bit               m_rdy1  [DEPTH];
  bit               m_rdy2  [DEPTH];
  logic [OP_W-1:0]  m_op    [DEPTH];
  logic [TAG_W-1:0] m_tag   [DEPTH];
  logic [TAG_W-1:0] m_q1    [DEPTH];
  logic [TAG_W-1:0] m_q2    [DEPTH];
  logic [XLEN-1:0]  m_pc    [DEPTH];
  logic [XLEN-1:0]  m_imm   [DEPTH];
  logic [XLEN-1:0]  m_v1    [DEPTH];
  logic [XLEN-1:0]  m_v2    [DEPTH];
  int unsigned      m_seq   [DEPTH];
  int unsigned      seq_ctr = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit snoop(input logic [TAG_W-1:0] q, output logic [XLEN-1:0] v);
    for (int k = 0; k < NCDB; k++)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q) begin
        v = cdb_val[k*XLEN +: XLEN];
        return 1'b1;
      end
    v = '0;
    return 1'b0;
  endfunction

  // Compare DUT outputs with the model, then advance the model to the next edge.
  task automatic model_step();
    int sel, fr, occ;
    bit exp_ir, exp_dv;
    logic [XLEN-1:0] v;
    if (!rst_in) clear_model();
    occ = 0; sel = -1; fr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) occ++;
      else if (fr < 0) fr = i;
      if (m_valid[i] && m_rdy1[i] && m_rdy2[i]) begin
`ifdef RS_AGE_SELECT_EN
        if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    exp_ir = rdy_in && (occ < DEPTH);
    exp_dv = (sel >= 0) && rdy_in && !flush_in;
    chk("occupancy", occupancy, occ);
    chk("issue_ready", issue_ready, exp_ir);
    chk("disp_valid", disp_valid, exp_dv);
    if (exp_dv) begin
      chk("disp_op", disp_op, m_op[sel]);
      chk("disp_tag", disp_tag, m_tag[sel]);
      chk("disp_pc", disp_pc, m_pc[sel]);
      chk("disp_imm", disp_imm, m_imm[sel]);
      chk("disp_v1", disp_v1, m_v1[sel]);
      chk("disp_v2", disp_v2, m_v2[sel]);
    end
    if (!rst_in || !rdy_in) return;
    if (flush_in) begin
      clear_model();
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && !m_rdy1[i] && snoop(m_q1[i], v)) begin m_rdy1[i] = 1'b1; m_v1[i] = v; end
      if (m_valid[i] && !m_rdy2[i] && snoop(m_q2[i], v)) begin m_rdy2[i] = 1'b1; m_v2[i] = v; end
    end
    if (exp_dv && disp_ready) m_valid[sel] = 1'b0;
    if (issue_valid && exp_ir) begin
      m_valid[fr] = 1'b1;
      m_op[fr] = issue_op; m_tag[fr] = issue_tag; m_pc[fr] = issue_pc; m_imm[fr] = issue_imm;
      m_q1[fr] = issue_q1; m_q2[fr] = issue_q2;
      m_rdy1[fr] = issue_rdy1; m_v1[fr] = issue_v1;
      m_rdy2[fr] = issue_rdy2; m_v2[fr] = issue_v2;
      if (!issue_rdy1 && snoop(issue_q1, v)) begin m_rdy1[fr] = 1'b1; m_v1[fr] = v; end
      if (!issue_rdy2 && snoop(issue_q2, v)) begin m_rdy2[fr] = 1'b1; m_v2[fr] = v; end
      m_seq[fr] = seq_ctr;
      seq_ctr++;
    end
  endtask

  // Called just after a falling edge with inputs set; ends after the next one.
  task automatic step();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; issue_valid = 1'b0; disp_ready = 1'b0;
    issue_op = '0; issue_tag = '0; issue_pc = '0; issue_imm = '0;
    issue_rdy1 = 1'b1; issue_rdy2 = 1'b1; issue_q1 = '0; issue_q2 = '0;
    issue_v1 = '0; issue_v2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
  endtask

  task automatic set_issue(input logic [TAG_W-1:0] tag, input bit r1, input logic [TAG_W-1:0] q1,
                           input logic [XLEN-1:0] v1, input bit r2, input logic [TAG_W-1:0] q2,
                           input logic [XLEN-1:0] v2);
    issue_valid = 1'b1; issue_op = rs_pkg::OP_ADD; issue_tag = tag;
    issue_pc = 32'h1000 + 32'(tag) * 4; issue_imm = 32'(tag) + 32'd7;
    issue_rdy1 = r1; issue_q1 = q1; issue_v1 = v1;
    issue_rdy2 = r2; issue_q2 = q2; issue_v2 = v2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    idle();
    rst_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset occupancy", occupancy, 0);
    chk("reset issue_ready", issue_ready, 1);
    chk("reset disp_valid", disp_valid, 0);
    chk("reset disp_tag", disp_tag, 0);
    chk("reset disp_v1", disp_v1, 0);
    step();
    rst_in = 1'b1;

    // Ready ADD dispatches one cycle after issue.
    set_issue(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    step();
    idle(); disp_ready = 1'b1;
    #1;
    chk("t1 disp_valid", disp_valid, 1);
    chk("t1 disp_tag", disp_tag, 3);
    chk("t1 disp_v1", disp_v1, 5);
    chk("t1 disp_v2", disp_v2, 7);
    step();
    #1;
    chk("t1 occupancy", occupancy, 0);
    step();

    // Wakeup from CDB channel 1.
    set_issue(4'd4, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd1);
    step();
    idle(); disp_ready = 1'b1;
    step();
    cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_val = {32'h1234, 32'h0};
    #1;
    chk("t2 disp_valid before", disp_valid, 0);
    step();
    idle(); disp_ready = 1'b1;
    #1;
    chk("t2 disp_valid after", disp_valid, 1);
    chk("t2 disp_v1", disp_v1, 32'h1234);
    step();

    // Issue-time bypass on source 2 from channel 0.
    idle();
    set_issue(4'd5, 1'b1, 4'd0, 32'd3, 1'b0, 4'd6, 32'd0);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd6}; cdb_val = {32'h0, 32'd9};
    step();
    idle(); disp_ready = 1'b1;
    #1;
    chk("t3 disp_valid", disp_valid, 1);
    chk("t3 disp_v2", disp_v2, 9);
    step();

    // Fill all slots, then free exactly one.
    idle();
    for (int t = 0; t < DEPTH; t++) begin
      set_issue(4'(t), 1'b1, 4'd0, 32'(t + 100), 1'b1, 4'd0, 32'(t + 200));
      step();
    end
    idle();
    #1;
    chk("t4 occupancy full", occupancy, 8);
    chk("t4 issue_ready full", issue_ready, 0);
    chk("t4 disp_tag", disp_tag, 0);
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    #1;
    chk("t4 occupancy after", occupancy, 7);
    chk("t4 issue_ready after", issue_ready, 1);
    step();

    // Drain, load 5 entries (3 waiting), flush with a simultaneous issue.
    idle(); disp_ready = 1'b1;
    for (int t = 0; t < 20 && occupancy != 0; t++) step();
    chk("t5 drained", occupancy, 0);
    idle();
    set_issue(4'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1); step();
    set_issue(4'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd2); step();
    set_issue(4'd3, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd3); step();
    set_issue(4'd4, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd4); step();
    set_issue(4'd5, 1'b1, 4'd0, 32'd5, 1'b0, 4'd11, 32'd0); step();
    set_issue(4'd6, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd6);
    flush_in = 1'b1; disp_ready = 1'b1;
    #1;
    chk("t5 occupancy pre-flush", occupancy, 5);
    chk("t5 disp_valid in flush", disp_valid, 0);
    step();
    idle();
    #1;
    chk("t5 occupancy post-flush", occupancy, 0);
    chk("t5 disp_valid post-flush", disp_valid, 0);
    step();

    // rdy_in low holds state through a broadcast and an issue attempt.
    set_issue(4'd7, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd8);
    step();
    for (int t = 0; t < 3; t++) begin
      idle();
      set_issue(4'd8, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
      rdy_in = 1'b0; disp_ready = 1'b1;
      cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_val = {32'h0, 32'h55};
      #1;
      chk("t6 hold disp_valid", disp_valid, 0);
      chk("t6 hold issue_ready", issue_ready, 0);
      chk("t6 hold occupancy", occupancy, 1);
      step();
    end
    idle();
    #1;
    chk("t6 still waiting", disp_valid, 0);
    chk("t6 occupancy kept", occupancy, 1);
    step();
    cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd3}; cdb_val = {32'h66, 32'h55};
    step();
    idle(); disp_ready = 1'b1;
    #1;
    chk("t6 woke disp_valid", disp_valid, 1);
    chk("t6 lowest channel wins", disp_v1, 32'h55);
    step();

    // Randomized traffic with one mid-run asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      rst_in      = (c == 1500) ? 1'b0 : 1'b1;
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 39) == 0);
      disp_ready  = ($urandom_range(0, 9) < 6);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_op    = OP_W'($urandom_range(0, 63));
      issue_tag   = TAG_W'($urandom_range(0, 15));
      issue_pc    = $urandom;
      issue_imm   = $urandom;
      issue_rdy1  = $urandom_range(0, 1) == 1;
      issue_rdy2  = $urandom_range(0, 1) == 1;
      issue_q1    = TAG_W'($urandom_range(0, 7));
      issue_q2    = TAG_W'($urandom_range(0, 7));
      issue_v1    = $urandom;
      issue_v2    = $urandom;
      for (int k = 0; k < NCDB; k++) begin
        cdb_valid[k]              = ($urandom_range(0, 9) < 4);
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
        cdb_val[k*XLEN +: XLEN]   = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
